// File: rtl/mul_ci_pkg.sv
// Shared op codes, FSM encoding and widths for the multiply custom-instruction front end.
package mul_ci_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned WD_W   = 16;

  localparam logic [1:0] OP_MUL   = 2'd0;
  localparam logic [1:0] OP_SQR   = 2'd1;
  localparam logic [1:0] OP_MAC   = 2'd2;
  localparam logic [1:0] OP_RDCLR = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

endpackage

// File: rtl/mul_ci_memo.sv
// Single-entry product memo: remembers the last engine operands/product and flags a repeat.
module mul_ci_memo
  import mul_ci_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clk_en,
  input  logic              wr_en,
  input  logic              inv,
  input  logic [DATA_W-1:0] wr_a,
  input  logic [DATA_W-1:0] wr_b,
  input  logic [DATA_W-1:0] wr_p,
  input  logic [DATA_W-1:0] cmp_a,
  input  logic [DATA_W-1:0] cmp_b,
  output logic              hit_c,
  output logic [DATA_W-1:0] prod_c
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, p_q, p_d;

  always_comb begin
    valid_d = valid_q;
    a_d     = a_q;
    b_d     = b_q;
    p_d     = p_q;
    if (inv) begin
      valid_d = 1'b0;
    end else if (wr_en) begin
      valid_d = 1'b1;
      a_d     = wr_a;
      b_d     = wr_b;
      p_d     = wr_p;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      p_q     <= '0;
    end else if (clk_en) begin
      valid_q <= valid_d;
      a_q     <= a_d;
      b_q     <= b_d;
      p_q     <= p_d;
    end
  end

  assign hit_c  = valid_q && (cmp_a == a_q) && (cmp_b == b_q);
  assign prod_c = p_q;

endmodule

// File: rtl/mul_ci_front.sv
// Nios II CI front end for the sequential multiplier: MUL/SQR/MAC/RDCLR with watchdog.
// Optional single-entry product memo enabled by defining MUL_CI_MEMO_EN.
module mul_ci_front
  import mul_ci_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned ACC_W   = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_en,
  input  logic        start,
  input  logic [1:0]  n,
  input  logic [31:0] dataa,
  input  logic [31:0] datab,
  output logic [31:0] result,
  output logic        done,
  output logic        err,
  output logic        eng_start,
  output logic [31:0] eng_dataa,
  output logic [31:0] eng_datab,
  input  logic [31:0] eng_result,
  input  logic        eng_done
);

  state_e            state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [31:0]       result_q, result_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              eng_start_q, eng_start_d;
  logic [31:0]       a_q, a_d, b_q, b_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [WD_W-1:0]   wd_q, wd_d;

  logic              resp_go;
  logic [31:0]       resp_prod;
  logic [31:0]       b_eff_c;
  logic              wd_hit_c;
  logic              memo_hit_c;
  logic [31:0]       memo_prod_c;

  assign b_eff_c  = (n == OP_SQR) ? dataa : datab;
  assign wd_hit_c = (wd_q == WD_W'(TIMEOUT));

`ifdef MUL_CI_MEMO_EN
  logic memo_wr_c, memo_inv_c;
  assign memo_wr_c  = (state_q == ST_WAIT) && eng_done;
  assign memo_inv_c = (state_q == ST_WAIT) && !eng_done && wd_hit_c;

  mul_ci_memo u_memo (
    .clk    (clk),
    .reset  (reset),
    .clk_en (clk_en),
    .wr_en  (memo_wr_c),
    .inv    (memo_inv_c),
    .wr_a   (a_q),
    .wr_b   (b_q),
    .wr_p   (eng_result),
    .cmp_a  (dataa),
    .cmp_b  (b_eff_c),
    .hit_c  (memo_hit_c),
    .prod_c (memo_prod_c)
  );
`else
  assign memo_hit_c  = 1'b0;
  assign memo_prod_c = '0;
`endif

  // Next state; the response is formed on the edge that enters RESP so done lands one cycle after eng_done.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    result_d    = result_q;
    done_d      = 1'b0;
    err_d       = err_q;
    eng_start_d = 1'b0;
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    wd_d        = wd_q;
    resp_go     = 1'b0;
    resp_prod   = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d = n;
          a_d  = dataa;
          b_d  = b_eff_c;
          if (n == OP_RDCLR) begin
            resp_go = 1'b1;
          end else if (memo_hit_c) begin
            resp_go   = 1'b1;
            resp_prod = memo_prod_c;
          end else begin
            state_d     = ST_ISSUE;
            eng_start_d = 1'b1;
          end
        end
      end
      ST_ISSUE: begin
        wd_d    = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (eng_done) begin
          resp_go   = 1'b1;
          resp_prod = eng_result;
        end else if (wd_hit_c) begin
          resp_go = 1'b1;
          err_d   = 1'b1;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (resp_go) begin
      state_d = ST_RESP;
      done_d  = 1'b1;
      unique case (op_d)
        OP_MUL, OP_SQR: result_d = resp_prod;
        OP_MAC: begin
          acc_d    = ACC_W'(acc_q + ACC_W'(resp_prod));
          result_d = 32'(acc_d);
        end
        OP_RDCLR: begin
          result_d = 32'(acc_q);
          acc_d    = '0;
          err_d    = 1'b0;
        end
        default: result_d = resp_prod;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_MUL;
      result_q    <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      eng_start_q <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      wd_q        <= '0;
    end else if (clk_en) begin
      state_q     <= state_d;
      op_q        <= op_d;
      result_q    <= result_d;
      done_q      <= done_d;
      err_q       <= err_d;
      eng_start_q <= eng_start_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      wd_q        <= wd_d;
    end
  end

  assign result    = result_q;
  assign done      = done_q;
  assign err       = err_q;
  assign eng_start = eng_start_q;
  assign eng_dataa = a_q;
  assign eng_datab = b_q;

endmodule

// File: tb/tb_mul_ci_front.sv
// Randomized self-checking bench for mul_ci_front with a latency-programmable engine model.
// Honours MUL_CI_MEMO_EN in its reference model when the design is built with it.
module tb_mul_ci_front;

  localparam int unsigned TMO = 100;

  logic        clk = 1'b0;
  logic        reset, clk_en, start;
  logic [1:0]  n;
  logic [31:0] dataa, datab, result, eng_dataa, eng_datab, eng_result;
  logic        done, err, eng_start, eng_done;

  mul_ci_front #(.TIMEOUT(TMO), .ACC_W(32)) dut (
    .clk(clk), .reset(reset), .clk_en(clk_en), .start(start), .n(n),
    .dataa(dataa), .datab(datab), .result(result), .done(done), .err(err),
    .eng_start(eng_start), .eng_dataa(eng_dataa), .eng_datab(eng_datab),
    .eng_result(eng_result), .eng_done(eng_done)
  );

  always #5 clk = ~clk;

  // Engine model: captures operands on eng_start, answers after eng_lat enabled cycles.
  int          eng_lat = 4;
  bit          eng_mute = 1'b0;
  int          e_cnt;
  bit          e_busy;
  logic [31:0] e_prod;

  always @(posedge clk) begin
    if (reset) begin
      e_busy   <= 1'b0;
      eng_done <= 1'b0;
      eng_result <= '0;
    end else if (clk_en) begin
      eng_done <= 1'b0;
      if (eng_start) begin
        e_busy <= 1'b1;
        e_cnt  <= eng_lat - 1;
        e_prod <= eng_dataa * eng_datab;
      end else if (e_busy) begin
        if (e_cnt == 0) begin
          e_busy     <= 1'b0;
          eng_done   <= !eng_mute;
          eng_result <= e_prod;
        end else begin
          e_cnt <= e_cnt - 1;
        end
      end
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference model state
  logic [31:0] acc_m = '0;
  bit          err_m = 1'b0;
  bit          m_valid = 1'b0;
  logic [31:0] m_a, m_b;

  task automatic model_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit mute, output logic [31:0] exp_r, output logic [31:0] beff,
                          output bit hit, output bit aborted);
    logic [31:0] p;
    beff = (op == 2'd1) ? a : b;
    hit  = 1'b0;
`ifdef MUL_CI_MEMO_EN
    hit = (op != 2'd3) && m_valid && (m_a == a) && (m_b == beff);
`endif
    aborted = (op != 2'd3) && !hit && mute;
    p = aborted ? 32'd0 : a * beff;
    case (op)
      2'd0, 2'd1: exp_r = p;
      2'd2: begin acc_m = acc_m + p; exp_r = acc_m; end
      default: begin exp_r = acc_m; acc_m = '0; err_m = 1'b0; end
    endcase
    if (aborted) err_m = 1'b1;
    if (op != 2'd3 && !hit) begin
      if (aborted) m_valid = 1'b0;
      else begin m_valid = 1'b1; m_a = a; m_b = beff; end
    end
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int lat, input bit mute);
    logic [31:0] exp_r, beff;
    bit hit, aborted;
    int cyc, done_cyc, edone_cyc, starts, start_cyc;
    model_op(op, a, b, mute, exp_r, beff, hit, aborted);
    eng_lat = lat;
    eng_mute = mute;
    @(negedge clk);
    start = 1'b1; n = op; dataa = a; datab = b;
    @(negedge clk);
    start = 1'b0; n = 2'($urandom); dataa = $urandom; datab = $urandom;
    cyc = 1; done_cyc = 0; edone_cyc = -1; starts = 0; start_cyc = 0;
    while (cyc < int'(TMO) + 20) begin
      if (eng_start) begin
        starts++;
        start_cyc = cyc;
        check("eng_dataa", eng_dataa, a);
        check("eng_datab", eng_datab, beff);
      end
      if (eng_done && edone_cyc < 0) edone_cyc = cyc;
      if (done) begin done_cyc = cyc; break; end
      @(negedge clk);
      cyc++;
    end
    check("done_seen", 32'(done_cyc != 0), 32'd1);
    check("result", result, exp_r);
    check("err", 32'(err), 32'(err_m));
    check("eng_dataa_hold", eng_dataa, a);
    if (op == 2'd3 || hit) begin
      check("fast_done_cyc", 32'(done_cyc), 32'd1);
      check("no_eng_start", 32'(starts), 32'd0);
    end else begin
      check("eng_start_cnt", 32'(starts), 32'd1);
      check("eng_start_cyc", 32'(start_cyc), 32'd1);
      if (aborted) check("abort_done_cyc", 32'(done_cyc), 32'(TMO + 3));
      else         check("done_after_eng", 32'(done_cyc), 32'(edone_cyc + 1));
    end
    @(negedge clk);
    check("done_pulse", 32'(done), 32'd0);
  endtask

  initial begin
    logic [31:0] exp_r, beff, la, lb, a, b;
    bit hit, aborted;
    int cyc;
    reset = 1'b1; clk_en = 1'b1; start = 1'b0; n = '0; dataa = '0; datab = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_result", result, 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_eng_start", 32'(eng_start), 32'd0);
    check("rst_eng_dataa", eng_dataa, 32'd0);
    check("rst_eng_datab", eng_datab, 32'd0);

    run_op(2'd0, 32'd7, 32'd6, 66, 1'b0);
    run_op(2'd1, 32'h0000FFFF, 32'hDEAD, 5, 1'b0);
    run_op(2'd2, 32'd3, 32'd4, 3, 1'b0);
    run_op(2'd2, 32'hFFFFFFFE, 32'd5, 7, 1'b0);
    run_op(2'd3, 32'd0, 32'd0, 1, 1'b0);
    run_op(2'd3, 32'd0, 32'd0, 1, 1'b0);
    run_op(2'd0, 32'd11, 32'd13, 4, 1'b1);
    run_op(2'd3, 32'd0, 32'd0, 1, 1'b0);
    run_op(2'd0, 32'd7, 32'd6, 6, 1'b0);
    run_op(2'd0, 32'd7, 32'd6, 6, 1'b0);

    la = 32'd7; lb = 32'd6;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) == 0) begin a = la; b = lb; end
      else begin a = $urandom; b = $urandom; end
      run_op(2'($urandom_range(0, 3)), a, b, $urandom_range(1, 12), $urandom_range(0, 9) == 0);
      la = a; lb = b;
    end

    // Reset in WAIT abandons a MAC; accumulator, err and memo all clear.
    eng_lat = 30; eng_mute = 1'b0;
    @(negedge clk); start = 1'b1; n = 2'd2; dataa = 32'd5; datab = 32'd5;
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_eng_start", 32'(eng_start), 32'd0);
    check("mid_rst_result", result, 32'd0);
    check("mid_rst_err", 32'(err), 32'd0);
    check("mid_rst_eng_dataa", eng_dataa, 32'd0);
    acc_m = '0; err_m = 1'b0; m_valid = 1'b0;
    run_op(2'd0, 32'd2, 32'd3, 3, 1'b0);
    run_op(2'd3, 32'd0, 32'd0, 1, 1'b0);

    // clk_en low freezes everything while eng_done is held.
    model_op(2'd0, 32'd9, 32'd9, 1'b0, exp_r, beff, hit, aborted);
    eng_lat = 4; eng_mute = 1'b0;
    @(negedge clk); start = 1'b1; n = 2'd0; dataa = 32'd9; datab = 32'd9;
    @(negedge clk); start = 1'b0;
    cyc = 1;
    while (!eng_done && cyc < 50) begin @(negedge clk); cyc++; end
    check("ce_eng_done", 32'(eng_done), 32'd1);
    clk_en = 1'b0;
    repeat (10) begin
      @(negedge clk);
      check("ce_hold_done", 32'(done), 32'd0);
    end
    check("ce_eng_held", 32'(eng_done), 32'd1);
    clk_en = 1'b1;
    @(negedge clk);
    check("ce_done", 32'(done), 32'd1);
    check("ce_result", result, exp_r);
    @(negedge clk);
    check("ce_done_pulse", 32'(done), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mul_ci_front.md
Name: mul_ci_front

Overview:
Nios II custom-instruction front end that sits directly upstream of the sequential 32x32 multiply engine (mul). Decodes the CI extension field n, latches operands, issues a one-cycle start to the engine, waits for its done, and shapes the response. Adds square and signed multiply-accumulate operations plus a watchdog. The CPU sees one multi-cycle CI. The engine sees a clean start/done client.

Parameters:
TIMEOUT, 255, engine cycles allowed in WAIT before abort (max 65535).
ACC_W, 32, accumulator width; only 32 is supported.

Ports:
clk  in  1  system clock; the only clock
reset  in  1  synchronous, active-high reset
clk_en  in  1  CI clock enable; when low, all state and outputs hold
start  in  1  CI start, single-cycle pulse from the CPU
n  in  2  op select: 0=MUL a*b, 1=SQR a*a, 2=MAC acc+=a*b, 3=RDCLR read acc then clear
dataa  in  32  operand A
datab  in  32  operand B (ignored for SQR and RDCLR)
result  out  32  CI result, registered, holds until the next response
done  out  1  one-cycle completion pulse
err  out  1  sticky watchdog-abort flag
eng_start  out  1  one-cycle start pulse to the engine
eng_dataa  out  32  engine operand A, stable from ISSUE until the response
eng_datab  out  32  engine operand B, stable from ISSUE until the response
eng_result  in  32  engine product, low 32 bits
eng_done  in  1  engine completion pulse

Behaviour:
- Reset (synchronous, active-high, sampled on the clk edge):
  - result=0, done=0, err=0, eng_start=0, eng_dataa=0, eng_datab=0.
  - Accumulator=0, watchdog=0, state=IDLE.
  - Reset mid-operation abandons the operation. No done is produced. The engine shares the reset.
- All state advances only when clk_en=1. done and eng_start are driven low in every state except RESP and ISSUE respectively.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - On start: latch the op code.
  - eng_dataa <= dataa.
  - eng_datab <= datab, or dataa when op=SQR.
  - op=RDCLR -> RESP. Otherwise -> ISSUE, or -> RESP directly on a memo hit (see Optional Feature).
  - start outside IDLE is ignored.
- ISSUE: eng_start=1 for exactly one cycle; watchdog<=0; -> WAIT.
- WAIT:
  - On eng_done: product<=eng_result; -> RESP.
  - Else if watchdog==TIMEOUT: product<=0, err<=1; -> RESP.
  - Else watchdog++.
  - If eng_done and the timeout coincide, eng_done wins.
- RESP (done=1 for one cycle, then -> IDLE):
  - MUL and SQR: result<=product.
  - MAC: acc<=acc+product, wrapping mod 2^32; result<=acc+product.
  - RDCLR: result<=acc, acc<=0, err<=0.
- Arithmetic:
  - The low-32 product is identical for signed and unsigned operands, so MAC is valid for two's-complement data.
  - No saturation anywhere.
- Latency:
  - start sampled at edge 0; eng_start high in cycle 1.
  - If eng_done is in cycle k, done is high in cycle k+1.
  - RDCLR: done in cycle 1.

Optional Feature:
MUL_CI_MEMO_EN.
- Defined:
  - A single-entry memo holds {valid, A, B, product}. It is written whenever the engine returns a product. It is invalidated by reset and by a watchdog abort.
  - For op 0, 1 or 2, if valid and the latched operands equal the memo operands, IDLE -> RESP using the memo product. eng_start is never pulsed and done appears in cycle 1.
- Undefined: there is no memo; every multiply goes through the engine.

Decomposition:
- Package mul_ci_pkg:
  - op-code localparams OP_MUL, OP_SQR, OP_MAC, OP_RDCLR.
  - FSM state encoding.
  - Watchdog counter width (16).
- Sub-module mul_ci_memo (compare plus register entry), instantiated only under MUL_CI_MEMO_EN.
- Accumulator, FSM and watchdog stay in the top level.

Test Plan:
- n=0, A=7, B=6, engine model with 66-cycle latency -> one eng_start pulse; done one cycle after eng_done; result=42.
- n=1, A=0x0000FFFF, B=0xDEAD -> eng_datab=0x0000FFFF; result=0xFFFE0001.
- n=2 with (3,4), then n=2 with (0xFFFFFFFE,5), then n=3 -> results 12, 2, 2. A second n=3 returns 0 with done in cycle 1.
- eng_done tied low, n=0 -> done at cycle TIMEOUT+3 with result=0 and err=1. A following n=3 clears err.
- Reset asserted during WAIT -> next edge gives done=0, eng_start=0, acc=0, state IDLE. A subsequent n=0 (2,3) returns 6.
- clk_en low for 10 cycles during WAIT with eng_done held -> no progress. Response arrives after clk_en returns.
- With MUL_CI_MEMO_EN, repeat n=0 (7,6) -> no eng_start; done in cycle 1; result=42.
